// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target engine.
package i2c_pkg;

  localparam int unsigned I2C_BYTE_BITS = 8;

  // Value of the R/W bit in the address byte.
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_tgt_state_e;

endpackage

// File: rtl/i2c_if.sv
// Open-drain I2C bus lines seen by a target: raw SCL/SDA in, SDA pull-down out.
interface i2c_if;

  logic SCL;
  logic SDA;
  logic sda_out_s;
  logic sda_oe_s;

  modport master (output SCL, output SDA, input sda_out_s, input sda_oe_s);
  modport slave  (input SCL, input SDA, output sda_out_s, output sda_oe_s);

endinterface

// File: rtl/i2c_line_sync.sv
// Multi-flop synchronizer for one bus line plus a history flop for edge detection.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the raw line in; lines reset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_target_engine.sv
// I2C target protocol engine: address match, register pointer, byte writes and reads.
module i2c_target_engine
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  i2c_if.slave                        bus,
  output logic [$clog2(NUM_REGS)-1:0] reg_addr,
  output logic                        reg_wr_en,
  output logic [7:0]                  reg_wr_data,
  input  logic [7:0]                  reg_rd_data,
  output logic                        busy
);

  localparam int unsigned AW       = $clog2(NUM_REGS);
  localparam int unsigned CNT_W    = $clog2(I2C_BYTE_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(I2C_BYTE_BITS - 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start, stop;

  i2c_tgt_state_e   state;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       shift;
  logic [7:0]       shift_in;
  logic             byte_done;
  logic             rw;
  logic             sda_oe;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (bus.SCL),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (bus.SDA),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start    = scl_lvl & sda_fall;
  assign stop     = scl_lvl & sda_rise;
  assign shift_in = {shift[6:0], sda_lvl};

  assign bus.sda_out_s = 1'b0;
  assign bus.sda_oe_s  = sda_oe;

  // Protocol FSM: sample on SCL rise, drive SDA on SCL fall; START/STOP override both.
  // byte_done marks "8th bit sampled, act on the next SCL fall", so a state owns its ACK slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      byte_done   <= 1'b0;
      rw          <= 1'b0;
      sda_oe      <= 1'b0;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      busy        <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      // Post-write pointer advance, one clk after the strobe.
      if (reg_wr_en) reg_addr <= reg_addr + 1'b1;

      if (start) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (stop) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR: begin
            shift   <= shift_in;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              if (shift_in[7:1] == TARGET_ADDR) begin
                busy      <= 1'b1;
                rw        <= shift_in[0];
                byte_done <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          PTR: begin
            shift   <= shift_in;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              reg_addr  <= shift_in[AW-1:0];
              byte_done <= 1'b1;
            end
          end
          WR_BYTE: begin
            shift   <= shift_in;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) byte_done <= 1'b1;
          end
          RD_BYTE: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) byte_done <= 1'b1;
          end
          RD_ACK: begin
            if (sda_lvl) state <= IGNORE;
            else         byte_done <= 1'b1;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              sda_oe    <= 1'b1;
              state     <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (rw == I2C_RW_WRITE) begin
              sda_oe <= 1'b0;
              state  <= PTR;
            end else begin
              shift  <= reg_rd_data;
              sda_oe <= ~reg_rd_data[7];
              state  <= RD_BYTE;
            end
          end
          PTR: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              sda_oe    <= 1'b1;
              state     <= PTR_ACK;
            end
          end
          PTR_ACK: begin
            sda_oe <= 1'b0;
            state  <= WR_BYTE;
          end
          WR_BYTE: begin
            if (byte_done) begin
              byte_done   <= 1'b0;
              sda_oe      <= 1'b1;
              reg_wr_en   <= 1'b1;
              reg_wr_data <= shift;
              state       <= WR_ACK;
            end
          end
          WR_ACK: begin
            sda_oe <= 1'b0;
            state  <= WR_BYTE;
          end
          RD_BYTE: begin
            // shift[7] is already on the bus, so the next bit to drive is shift[6].
            if (byte_done) begin
              byte_done <= 1'b0;
              sda_oe    <= 1'b0;
              reg_addr  <= reg_addr + 1'b1;
              state     <= RD_ACK;
            end else begin
              sda_oe <= ~shift[6];
              shift  <= {shift[6:0], 1'b0};
            end
          end
          RD_ACK: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              shift     <= reg_rd_data;
              sda_oe    <= ~reg_rd_data[7];
              state     <= RD_BYTE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_engine.sv
// Self-checking bench for i2c_target_engine: bench-side I2C master, register file and reference model.
module tb_i2c_target_engine;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned AW       = 4;
  localparam logic [7:0]  ADDR_W   = 8'hA0;
  localparam logic [7:0]  ADDR_R   = 8'hA1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_if bus_if ();

  logic          m_sda      = 1'b1;
  logic          allow_edge = 1'b0;
  logic          sda_line;
  logic [AW-1:0] reg_addr;
  logic          reg_wr_en;
  logic [7:0]    reg_wr_data;
  logic [7:0]    reg_rd_data;
  logic          busy;
  logic [7:0]    regs [NUM_REGS] = '{default: 8'h00};

  assign sda_line    = m_sda & (bus_if.sda_oe_s ? bus_if.sda_out_s : 1'b1);
  assign bus_if.SDA  = sda_line;
  assign reg_rd_data = regs[reg_addr];

  i2c_target_engine #(
    .TARGET_ADDR (7'h50),
    .NUM_REGS    (NUM_REGS),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .reg_addr    (reg_addr),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_data (reg_wr_data),
    .reg_rd_data (reg_rd_data),
    .busy        (busy)
  );

  // Register file, write log and bus-line monitors (record only).
  int unsigned   od_err = 0, out_err = 0, oe_cycles = 0, busy_cycles = 0;
  logic          prev_scl = 1'b1, prev_sda = 1'b1;
  logic [AW-1:0] wr_addr_q[$];
  logic [7:0]    wr_data_q[$];

  always @(posedge clk) begin
    if (reg_wr_en === 1'b1) begin
      regs[reg_addr] <= reg_wr_data;
      wr_addr_q.push_back(reg_addr);
      wr_data_q.push_back(reg_wr_data);
    end
    if (!rst && prev_scl === 1'b1 && bus_if.SCL === 1'b1 && sda_line !== prev_sda && !allow_edge)
      od_err++;
    if (bus_if.sda_out_s !== 1'b0) out_err++;
    if (bus_if.sda_oe_s === 1'b1) oe_cycles++;
    if (busy === 1'b1) busy_cycles++;
    prev_scl = bus_if.SCL;
    prev_sda = sda_line;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state.
  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned m_ptr = 0;
  logic [7:0]  model_regs [NUM_REGS] = '{default: 8'h00};
  logic [7:0]  wr_bytes[$];
  logic [7:0]  rd_q[$];

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (bus_if.SCL === 1'b0) begin
      m_sda = 1'b1; wclk(4);
      bus_if.SCL = 1'b1; wclk(4);
    end
    allow_edge = 1'b1; m_sda = 1'b0; wclk(4);
    allow_edge = 1'b0; bus_if.SCL = 1'b0; wclk(4);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wclk(4);
    bus_if.SCL = 1'b1; wclk(4);
    allow_edge = 1'b1; m_sda = 1'b1; wclk(4);
    allow_edge = 1'b0; wclk(4);
  endtask

  task automatic clock_bit(input logic b, output logic r);
    m_sda = b; wclk(4);
    bus_if.SCL = 1'b1; wclk(4);
    r = sda_line; wclk(4);
    bus_if.SCL = 1'b0; wclk(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic master_nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      d[i] = r;
    end
    clock_bit(master_nack, r);
  endtask

  // Write frame: address, pointer, then wr_bytes; counts target NACKs.
  task automatic do_write(input logic [7:0] ptr, output int unsigned nacks, output logic busy_mid);
    logic a;
    nacks = 0;
    bus_start();
    send_byte(ADDR_W, a); if (a !== 1'b0) nacks++;
    busy_mid = busy;
    send_byte(ptr, a); if (a !== 1'b0) nacks++;
    foreach (wr_bytes[i]) begin
      send_byte(wr_bytes[i], a); if (a !== 1'b0) nacks++;
    end
    bus_stop();
  endtask

  // Pointer write, repeated START, read n bytes (NACK on the last), STOP.
  task automatic do_read(input logic [7:0] ptr, input int unsigned n, output int unsigned nacks);
    logic a;
    logic [7:0] d;
    nacks = 0;
    rd_q.delete();
    bus_start();
    send_byte(ADDR_W, a); if (a !== 1'b0) nacks++;
    send_byte(ptr, a);    if (a !== 1'b0) nacks++;
    bus_start();
    send_byte(ADDR_R, a); if (a !== 1'b0) nacks++;
    for (int unsigned i = 0; i < n; i++) begin
      recv_byte(i == n - 1, d);
      rd_q.push_back(d);
    end
    bus_stop();
  endtask

  task automatic test_reset();
    rst = 1'b1; wclk(4);
    rst = 1'b0; wclk(2);
    n_cmp++; if (bus_if.sda_oe_s !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b want 0", bus_if.sda_oe_s); end
    n_cmp++; if (bus_if.sda_out_s !== 1'b0) begin n_bad++; $display("FAIL reset_out: got %b want 0", bus_if.sda_out_s); end
    n_cmp++; if (reg_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", reg_addr); end
    n_cmp++; if (reg_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", reg_wr_en); end
    n_cmp++; if (reg_wr_data !== 8'h00) begin n_bad++; $display("FAIL reset_wr_data: got %h want 00", reg_wr_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    int unsigned nacks, base;
    logic bm;
    logic [AW-1:0] ea;
    base = wr_addr_q.size();
    wr_bytes = '{8'h5A, 8'hC3};
    do_write(8'h03, nacks, bm);
    n_cmp++; if (nacks !== 0) begin n_bad++; $display("FAIL write_acks: got %0d nacks want 0", nacks); end
    n_cmp++; if (bm !== 1'b1) begin n_bad++; $display("FAIL write_busy_mid: got %b want 1", bm); end
    n_cmp++; if (wr_addr_q.size() - base !== 2) begin n_bad++; $display("FAIL write_count: got %0d want 2", wr_addr_q.size() - base); end
    for (int unsigned i = 0; i < 2; i++) begin
      ea = AW'((3 + i) % NUM_REGS);
      model_regs[ea] = wr_bytes[i];
      n_cmp++;
      if (base + i >= wr_addr_q.size() || wr_addr_q[base + i] !== ea || wr_data_q[base + i] !== wr_bytes[i]) begin
        n_bad++; $display("FAIL write_strobe%0d: missing or wrong entry, want addr %0d data %h", i, ea, wr_bytes[i]);
      end
    end
    m_ptr = (3 + 2) % NUM_REGS;
    n_cmp++; if (reg_addr !== AW'(m_ptr)) begin n_bad++; $display("FAIL write_ptr: got %0d want %0d", reg_addr, m_ptr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL write_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_read_wrap();
    int unsigned nacks;
    logic bm;
    logic [7:0] exp_d;
    wr_bytes = '{8'h11, 8'h22, 8'h33};
    do_write(8'h0E, nacks, bm);
    for (int unsigned i = 0; i < 3; i++) model_regs[(14 + i) % NUM_REGS] = wr_bytes[i];
    n_cmp++; if (nacks !== 0) begin n_bad++; $display("FAIL preload_acks: got %0d nacks want 0", nacks); end
    do_read(8'h0E, 3, nacks);
    n_cmp++; if (nacks !== 0) begin n_bad++; $display("FAIL read_acks: got %0d nacks want 0", nacks); end
    for (int unsigned i = 0; i < 3; i++) begin
      exp_d = model_regs[(14 + i) % NUM_REGS];
      n_cmp++;
      if (rd_q[i] !== exp_d) begin n_bad++; $display("FAIL read_byte%0d: got %h want %h", i, rd_q[i], exp_d); end
    end
    m_ptr = (14 + 3) % NUM_REGS;
    n_cmp++; if (reg_addr !== AW'(m_ptr)) begin n_bad++; $display("FAIL read_ptr_wrap: got %0d want %0d", reg_addr, m_ptr); end
  endtask

  task automatic test_wrong_addr();
    int unsigned base, oe0, busy0;
    logic a1, a2;
    base = wr_addr_q.size(); oe0 = oe_cycles; busy0 = busy_cycles;
    bus_start();
    send_byte(8'h52, a1);
    send_byte(8'h77, a2);
    bus_stop();
    n_cmp++; if (a1 !== 1'b1 || a2 !== 1'b1) begin n_bad++; $display("FAIL wrong_addr_ack: got %b%b want 11", a1, a2); end
    n_cmp++; if (oe_cycles !== oe0) begin n_bad++; $display("FAIL wrong_addr_drive: got %0d oe cycles want 0", oe_cycles - oe0); end
    n_cmp++; if (busy_cycles !== busy0) begin n_bad++; $display("FAIL wrong_addr_busy: got %0d busy cycles want 0", busy_cycles - busy0); end
    n_cmp++; if (wr_addr_q.size() !== base) begin n_bad++; $display("FAIL wrong_addr_write: got %0d strobes want 0", wr_addr_q.size() - base); end
    n_cmp++; if (reg_addr !== AW'(m_ptr)) begin n_bad++; $display("FAIL wrong_addr_ptr: got %0d want %0d", reg_addr, m_ptr); end
  endtask

  task automatic test_abort();
    int unsigned base, nacks;
    logic a, r, bm;
    logic [7:0] d;
    base = wr_addr_q.size();
    bus_start();
    send_byte(ADDR_W, a);
    send_byte(8'h07, a);
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), r);
    bus_stop();
    m_ptr = 7;
    n_cmp++; if (wr_addr_q.size() !== base) begin n_bad++; $display("FAIL abort_write: got %0d strobes want 0", wr_addr_q.size() - base); end
    n_cmp++; if (bus_if.sda_oe_s !== 1'b0) begin n_bad++; $display("FAIL abort_oe: got %b want 0", bus_if.sda_oe_s); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (reg_addr !== AW'(m_ptr)) begin n_bad++; $display("FAIL abort_ptr: got %0d want %0d", reg_addr, m_ptr); end
    d = 8'($urandom_range(0, 255));
    wr_bytes = '{d};
    base = wr_addr_q.size();
    do_write(8'h09, nacks, bm);
    model_regs[9] = d;
    m_ptr = 10;
    n_cmp++; if (nacks !== 0) begin n_bad++; $display("FAIL abort_next_acks: got %0d nacks want 0", nacks); end
    n_cmp++;
    if (wr_addr_q.size() != base + 1 || wr_addr_q[base] !== AW'(9) || wr_data_q[base] !== d) begin
      n_bad++; $display("FAIL abort_next_write: missing or wrong entry, want addr 9 data %h", d);
    end
  endtask

  task automatic test_reset_mid_ack();
    logic r;
    logic [7:0] b;
    b = ADDR_W;
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    n_cmp++; if (bus_if.sda_oe_s !== 1'b1) begin n_bad++; $display("FAIL rst_ack_pre: got oe %b want 1", bus_if.sda_oe_s); end
    rst = 1'b1; wclk(1);
    n_cmp++; if (bus_if.sda_oe_s !== 1'b0) begin n_bad++; $display("FAIL rst_ack_oe: got %b want 0", bus_if.sda_oe_s); end
    n_cmp++;
    if (reg_addr !== '0 || reg_wr_en !== 1'b0 || reg_wr_data !== 8'h00 || busy !== 1'b0 || bus_if.sda_out_s !== 1'b0) begin
      n_bad++; $display("FAIL rst_ack_outs: got addr %0d wr_en %b data %h busy %b want all 0", reg_addr, reg_wr_en, reg_wr_data, busy);
    end
    rst = 1'b0; wclk(2);
    clock_bit(1'b1, r);
    bus_stop();
    m_ptr = 0;
  endtask

  task automatic test_random();
    int unsigned nacks, base, n, p;
    logic bm;
    logic [7:0] ptr;
    logic [AW-1:0] ea;
    for (int it = 0; it < 6; it++) begin
      ptr = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      p = ptr % NUM_REGS;
      wr_bytes.delete();
      for (int unsigned i = 0; i < n; i++) wr_bytes.push_back(8'($urandom_range(0, 255)));
      base = wr_addr_q.size();
      do_write(ptr, nacks, bm);
      n_cmp++; if (nacks !== 0) begin n_bad++; $display("FAIL rnd%0d_wr_acks: got %0d nacks want 0", it, nacks); end
      for (int unsigned i = 0; i < n; i++) begin
        ea = AW'((p + i) % NUM_REGS);
        model_regs[ea] = wr_bytes[i];
        n_cmp++;
        if (base + i >= wr_addr_q.size() || wr_addr_q[base + i] !== ea || wr_data_q[base + i] !== wr_bytes[i]) begin
          n_bad++; $display("FAIL rnd%0d_wr%0d: missing or wrong entry, want addr %0d data %h", it, i, ea, wr_bytes[i]);
        end
      end
      m_ptr = (p + n) % NUM_REGS;
      n_cmp++; if (reg_addr !== AW'(m_ptr)) begin n_bad++; $display("FAIL rnd%0d_wr_ptr: got %0d want %0d", it, reg_addr, m_ptr); end
      do_read(ptr, n, nacks);
      n_cmp++; if (nacks !== 0) begin n_bad++; $display("FAIL rnd%0d_rd_acks: got %0d nacks want 0", it, nacks); end
      for (int unsigned i = 0; i < n; i++) begin
        n_cmp++;
        if (rd_q[i] !== model_regs[(p + i) % NUM_REGS]) begin
          n_bad++; $display("FAIL rnd%0d_rd%0d: got %h want %h", it, i, rd_q[i], model_regs[(p + i) % NUM_REGS]);
        end
      end
      n_cmp++; if (reg_addr !== AW'(m_ptr)) begin n_bad++; $display("FAIL rnd%0d_rd_ptr: got %0d want %0d", it, reg_addr, m_ptr); end
    end
  endtask

  task automatic test_open_drain();
    n_cmp++; if (out_err !== 0) begin n_bad++; $display("FAIL od_out_zero: got %0d bad cycles want 0", out_err); end
    n_cmp++; if (od_err !== 0) begin n_bad++; $display("FAIL od_sda_stable: got %0d changes while SCL high want 0", od_err); end
  endtask

  initial begin
    bus_if.SCL = 1'b1;
    test_reset();
    test_write();
    test_read_wrap();
    test_wrong_addr();
    test_abort();
    test_reset_mid_ack();
    test_random();
    test_open_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
